cart_slot_loader: RTL and testbench

- Parametrised successor to the single-cartridge HPS ioctl download path; sits between hps_io ioctl outputs and the cartridge RAM write port.
- Routes each download to one of NUM_SLOTS MPI cartridge slots, selected by ioctl_index.
- Packs the byte stream into DATA_W-bit words, buffers them in a small FIFO, and writes them through a req/ack memory handshake.
- Applies backpressure to the HPS through ioctl_wait and reports per-slot loaded flags and the size of the last load.

---
 rtl/cart_slot_loader.sv | 223 ++++++++++++++++++++++
 tb/tb_cart_slot_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_slot_loader.sv
// HPS ioctl download -> multi-slot cartridge RAM writer: packs bytes into words, FIFO-buffers them, req/ack writes.
// Optional: define CART_CKSUM_EN to build the 16-bit byte checksum on cksum (otherwise cksum is tied to 0).
module cart_slot_loader #(
    parameter int NUM_SLOTS  = 4,
    parameter int INDEX_BASE = 1,
    parameter int DATA_W     = 16,
    parameter int SLOT_AW    = 15,
    parameter int FIFO_DEPTH = 4,
    localparam int MAW       = SLOT_AW - $clog2(DATA_W / 8)
) (
    input  logic                 CLK50MHZ,
    input  logic                 COCO_RESET_N,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_data,
    output logic                 ioctl_wait,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [2:0]           mem_slot,
    output logic [MAW-1:0]       mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [SLOT_AW:0]     last_size,
    output logic                 load_done,
    output logic                 load_err,
    output logic [15:0]          cksum,
    output logic [1:0]           state_dbg
);
    localparam int BYTES  = DATA_W / 8;
    localparam int LB     = $clog2(BYTES);
    localparam int LANE_W = (LB > 0) ? LB : 1;
    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CW     = PW + 1;
    localparam logic [8:0] IDX_LO = 9'(INDEX_BASE);
    localparam logic [8:0] IDX_HI = 9'(INDEX_BASE + NUM_SLOTS);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;

    // Handshake: a write transfers on a clock edge where mem_req=1 and mem_ack=1;
    // mem_slot/mem_addr/mem_data stay stable from the rising of mem_req until that edge.
    state_t               state, state_next;
    logic                 dl_q;
    logic [2:0]           slot_q;
    logic [DATA_W-1:0]    pack_data, pack_data_n;
    logic [BYTES-1:0]     pack_mask, pack_mask_n;
    logic [MAW-1:0]       pack_waddr, pack_waddr_n;
    logic [DATA_W-1:0]    fifo_data [FIFO_DEPTH];
    logic [MAW-1:0]       fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count, count_next;
    logic                 wait_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic [SLOT_AW:0]     last_size_q;
    logic                 load_err_q;

    logic                 dl_rise, dl_fall, idx_ok, load_entry;
    logic                 byte_take, byte_ok, byte_bad, in_range;
    logic                 push, pop;
    logic [DATA_W-1:0]    push_data;
    logic [MAW-1:0]       push_addr, byte_waddr;
    logic [LANE_W-1:0]    lane;
    logic [2:0]           slot_new;
    logic [SLOT_AW:0]     addr_plus;

    assign dl_rise    = ioctl_download & ~dl_q;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign idx_ok     = ({1'b0, ioctl_index} >= IDX_LO) && ({1'b0, ioctl_index} < IDX_HI);
    assign slot_new   = 3'({1'b0, ioctl_index} - IDX_LO);
    assign in_range   = (ioctl_addr >> SLOT_AW) == 25'd0;
    assign byte_take  = (state == LOAD) && ioctl_wr;
    assign byte_ok    = byte_take && in_range;
    assign byte_bad   = byte_take && !in_range;
    assign byte_waddr = ioctl_addr[SLOT_AW-1:LB];
    assign lane       = LANE_W'(ioctl_addr % 25'(BYTES));
    assign addr_plus  = {1'b0, ioctl_addr[SLOT_AW-1:0]} + {{SLOT_AW{1'b0}}, 1'b1};
    assign pop        = mem_req && mem_ack;

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            state <= IDLE;
            dl_q  <= 1'b0;
        end else begin
            state <= state_next;
            dl_q  <= ioctl_download;
        end
    end

    always_comb begin
        state_next = state;
        load_entry = 1'b0;
        case (state)
            IDLE:  if (dl_rise && idx_ok) begin
                       state_next = LOAD;
                       load_entry = 1'b1;
                   end
            LOAD:  if (dl_fall) state_next = FLUSH;
            FLUSH: if (pack_mask == '0 && count == '0) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pack register keeps unwritten lanes at 8'hFF so a partial word can be pushed as-is.
    always_comb begin
        push         = 1'b0;
        push_data    = pack_data;
        push_addr    = pack_waddr;
        pack_data_n  = pack_data;
        pack_mask_n  = pack_mask;
        pack_waddr_n = pack_waddr;
        if (load_entry) begin
            pack_data_n = '1;
            pack_mask_n = '0;
        end else if (byte_ok) begin
            if (pack_mask != '0 && byte_waddr != pack_waddr) begin
                push        = 1'b1;
                pack_data_n = '1;
                pack_mask_n = '0;
            end
            pack_data_n[(BYTES - 1 - int'(lane)) * 8 +: 8] = ioctl_data;
            pack_mask_n[lane] = 1'b1;
            pack_waddr_n      = byte_waddr;
            if (&pack_mask_n) begin
                push        = 1'b1;
                push_data   = pack_data_n;
                push_addr   = byte_waddr;
                pack_data_n = '1;
                pack_mask_n = '0;
            end
        end else if (state == FLUSH && pack_mask != '0) begin
            push        = 1'b1;
            pack_data_n = '1;
            pack_mask_n = '0;
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            pack_data  <= '1;
            pack_mask  <= '0;
            pack_waddr <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            wait_q     <= 1'b0;
        end else begin
            pack_data  <= pack_data_n;
            pack_mask  <= pack_mask_n;
            pack_waddr <= pack_waddr_n;
            count      <= count_next;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            // One entry stays spare so a strobe landing in the same cycle as wait still fits.
            wait_q <= (count_next >= CW'(FIFO_DEPTH - 1)) ||
                      (state_next == FLUSH && pack_mask_n != '0);
        end
    end

    always_ff @(posedge CLK50MHZ) begin
        if (push) begin
            fifo_data[wr_ptr] <= push_data;
            fifo_addr[wr_ptr] <= push_addr;
        end
    end

    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N) begin
            slot_q       <= '0;
            slot_valid_q <= '0;
            last_size_q  <= '0;
            load_err_q   <= 1'b0;
        end else if (load_entry) begin
            slot_q      <= slot_new;
            last_size_q <= '0;
            load_err_q  <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++)
                if (slot_new == 3'(i)) slot_valid_q[i] <= 1'b0;
        end else begin
            if (byte_bad) load_err_q <= 1'b1;
            if (byte_ok && addr_plus > last_size_q) last_size_q <= addr_plus;
            if (state == DONE && !load_err_q && last_size_q != '0)
                for (int i = 0; i < NUM_SLOTS; i++)
                    if (slot_q == 3'(i)) slot_valid_q[i] <= 1'b1;
        end
    end

`ifdef CART_CKSUM_EN
    logic [15:0] cksum_q;
    always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
        if (!COCO_RESET_N)   cksum_q <= '0;
        else if (load_entry) cksum_q <= '0;
        else if (byte_ok)    cksum_q <= cksum_q + {8'd0, ioctl_data};
    end
    assign cksum = cksum_q;
`else
    assign cksum = '0;
`endif

    assign mem_req    = count != '0;
    assign mem_slot   = mem_req ? slot_q : 3'd0;
    assign mem_addr   = mem_req ? fifo_addr[rd_ptr] : '0;
    assign mem_data   = mem_req ? fifo_data[rd_ptr] : '0;
    assign ioctl_wait = wait_q;
    assign slot_valid = slot_valid_q;
    assign last_size  = last_size_q;
    assign load_err   = load_err_q;
    assign load_done  = state == DONE;
    assign state_dbg  = state;

    assert property (@(posedge CLK50MHZ) disable iff (!COCO_RESET_N)
        !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_cart_slot_loader.sv
// Directed bench for cart_slot_loader at default parameters (4 slots, 16-bit words, 32 KB slots).
module tb_cart_slot_loader;
    localparam int SW = 3 + 14 + 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = 8'd0;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_ack;
    logic        ack_en = 1'b1;
    logic [2:0]  mem_slot;
    logic [13:0] mem_addr;
    logic [15:0] mem_data;
    logic [3:0]  slot_valid;
    logic [15:0] last_size;
    logic        load_done;
    logic        load_err;
    logic [15:0] cksum;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [SW-1:0] exp_q[$];

    assign mem_ack = ack_en;

    cart_slot_loader dut (
        .CLK50MHZ(clk), .COCO_RESET_N(rst_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wait(ioctl_wait), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_slot(mem_slot), .mem_addr(mem_addr), .mem_data(mem_data),
        .slot_valid(slot_valid), .last_size(last_size), .load_done(load_done),
        .load_err(load_err), .cksum(cksum), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_ck(input logic [15:0] v);
`ifdef CART_CKSUM_EN
        return v;
`else
        return 16'd0 & v;
`endif
    endfunction

    function automatic logic [SW-1:0] wr_item(input logic [2:0] s, input logic [13:0] a, input logic [15:0] d);
        return {s, a, d};
    endfunction

    // Scoreboard: a write completes on the next posedge when req and ack are both high here.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (exp_q.size() == 0)
                check_eq("mem_unexpected", 64'(exp_q.size()), 64'd1);
            else
                check_eq("mem_write", {mem_slot, mem_addr, mem_data}, exp_q.pop_front());
        end
    end

    task automatic start_load(input logic [7:0] idx);
        @(negedge clk);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check_eq("wait_timeout", ioctl_wait, 1'b0);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    task automatic end_load(input string tag);
        int n = 0;
        ioctl_download = 1'b0;
        while (!load_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done"}, load_done, 1'b1);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, load_done, 1'b0);
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [15:0] sum;
        logic [7:0]  b [16];
        int req_cnt, done_cnt;

        repeat (3) @(negedge clk);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_wait", ioctl_wait, 1'b0);
        check_eq("rst_valid", slot_valid, 4'd0);
        check_eq("rst_size", last_size, 16'd0);
        check_eq("rst_done", load_done, 1'b0);
        check_eq("rst_err", load_err, 1'b0);
        check_eq("rst_cksum", cksum, 16'd0);
        check_eq("rst_state", state_dbg, 2'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Index 1 -> slot 0, four bytes, immediate ack.
        exp_q.push_back(wr_item(3'd0, 14'd0, 16'h1234));
        exp_q.push_back(wr_item(3'd0, 14'd1, 16'h5678));
        start_load(8'd1);
        check_eq("t1_state_load", state_dbg, 2'd1);
        send_byte(25'd0, 8'h12);
        send_byte(25'd1, 8'h34);
        send_byte(25'd2, 8'h56);
        send_byte(25'd3, 8'h78);
        end_load("t1");
        check_eq("t1_valid", slot_valid, 4'b0001);
        check_eq("t1_size", last_size, 16'd4);
        check_eq("t1_err", load_err, 1'b0);
        check_eq("t1_cksum", cksum, exp_ck(16'h0114));

        // Index 3 -> slot 2, odd length: tail lane padded with FF.
        exp_q.push_back(wr_item(3'd2, 14'd0, 16'hAABB));
        exp_q.push_back(wr_item(3'd2, 14'd1, 16'hCCFF));
        start_load(8'd3);
        send_byte(25'd0, 8'hAA);
        send_byte(25'd1, 8'hBB);
        send_byte(25'd2, 8'hCC);
        end_load("t2");
        check_eq("t2_valid", slot_valid, 4'b0101);
        check_eq("t2_size", last_size, 16'd3);
        check_eq("t2_cksum", cksum, exp_ck(16'h0231));

        // Index 2 -> slot 1, 16 bytes with ack withheld for 50 cycles.
        sum = 16'd0;
        for (int i = 0; i < 16; i++) begin
            b[i] = 8'(i * 17 + 3);
            sum  = sum + {8'd0, b[i]};
        end
        for (int k = 0; k < 8; k++) exp_q.push_back(wr_item(3'd1, 14'(k), {b[2*k], b[2*k+1]}));
        ack_en = 1'b0;
        start_load(8'd2);
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    send_byte(25'(i), b[i]);
                    if (i == 3) check_eq("t3_wait_at_2", ioctl_wait, 1'b0);
                    if (i == 5) begin
                        check_eq("t3_wait_at_3", ioctl_wait, 1'b1);
                        check_eq("t3_req_held", mem_req, 1'b1);
                    end
                end
            end
            begin
                repeat (50) @(negedge clk);
                check_eq("t3_wait_stall", ioctl_wait, 1'b1);
                ack_en = 1'b1;
            end
        join
        end_load("t3");
        check_eq("t3_valid", slot_valid, 4'b0111);
        check_eq("t3_size", last_size, 16'd16);
        check_eq("t3_cksum", cksum, exp_ck(sum));

        // Index 1 with an out-of-slot address: dropped, error, slot 0 invalidated.
        exp_q.push_back(wr_item(3'd0, 14'd0, 16'h5AFF));
        start_load(8'd1);
        send_byte(25'h8000, 8'h77);
        send_byte(25'd0, 8'h5A);
        end_load("t4");
        check_eq("t4_err", load_err, 1'b1);
        check_eq("t4_valid", slot_valid, 4'b0110);
        check_eq("t4_size", last_size, 16'd1);
        check_eq("t4_cksum", cksum, exp_ck(16'h005A));

        // Index 9 is out of range: everything ignored.
        req_cnt  = 0;
        done_cnt = 0;
        start_load(8'd9);
        send_byte(25'd0, 8'h11);
        send_byte(25'd1, 8'h22);
        ioctl_download = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req)   req_cnt++;
            if (load_done) done_cnt++;
        end
        check_eq("t5_req", 64'(req_cnt), 64'd0);
        check_eq("t5_done", 64'(done_cnt), 64'd0);
        check_eq("t5_wait", ioctl_wait, 1'b0);
        check_eq("t5_state", state_dbg, 2'd0);
        check_eq("t5_valid", slot_valid, 4'b0110);
        check_eq("t5_size", last_size, 16'd1);
        check_eq("t5_err", load_err, 1'b1);

        // Asynchronous reset mid-load with a request pending.
        ack_en = 1'b0;
        start_load(8'd1);
        send_byte(25'd0, 8'hDE);
        send_byte(25'd1, 8'hAD);
        check_eq("t6_req_pending", mem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        ioctl_download = 1'b0;
        #1;
        check_eq("t6_req_cleared", mem_req, 1'b0);
        check_eq("t6_valid", slot_valid, 4'd0);
        check_eq("t6_state", state_dbg, 2'd0);
        check_eq("t6_size", last_size, 16'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        exp_q.push_back(wr_item(3'd0, 14'd0, 16'hC33C));
        start_load(8'd1);
        send_byte(25'd0, 8'hC3);
        send_byte(25'd1, 8'h3C);
        end_load("t6");
        check_eq("t6_valid_after", slot_valid, 4'b0001);
        check_eq("t6_size_after", last_size, 16'd2);
        check_eq("t6_cksum", cksum, exp_ck(16'h00FF));

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
